// File: rtl/mips_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding,
// instruction width and the queue entry layout.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} words.
// Flush empties it and overrides any push/pop in the same cycle.
// Storage is cleared on reset so the head reads as zero while in reset.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one outstanding imem request at a time,
// captures the PC at grant, queues {pc, instr} and hands them to decode.
// The PC register has no enable, so pc_hold is low only in a granted cycle.
// A queue slot is reserved at request time, so the queue never overflows.
// Optional build macro: FETCH_ALIGN_CHECK_EN adds a misaligned-PC check
// that suppresses the request and raises inst_fault until the next flush.
//
// state  | meaning
// S_IDLE | first cycle after reset release, no request
// S_REQ  | request asserted when a queue slot is free
// S_WAIT | request granted, waiting for rvalid
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       pc_value,
  input  logic               flush,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               pc_hold,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst_data,
  output logic [N-1:0]       inst_pc,
  input  logic               inst_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               inst_fault
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t       state_q;
  logic               drop_q;
  logic [N-1:0]       pc_cap_q;
  logic [CW-1:0]      q_count;
  logic               q_empty;
  logic [N+INSTR_W-1:0] q_rdata;
  logic               room;
  logic               misalign;
  logic               grant;
  logic               resp;
  logic               push;
  logic               pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic inst_fault_q;

  assign misalign   = (state_q == S_REQ) && (pc_value[1:0] != 2'b00);
  assign inst_fault = inst_fault_q | misalign;

  // Sticky fault flag, cleared only by a redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          inst_fault_q <= 1'b0;
    else if (flush)    inst_fault_q <= 1'b0;
    else if (misalign) inst_fault_q <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  // Only one request in flight, so occupancy alone tells whether a slot is free
  assign room      = (q_count < DEPTH_C);
  assign imem_req  = (state_q == S_REQ) && room && !misalign;
  assign imem_addr = pc_value;
  assign grant     = imem_req && imem_gnt;
  assign pc_hold   = !grant;

  assign resp = (state_q == S_WAIT) && imem_rvalid;
  assign push = resp && !drop_q && !flush;
  assign pop  = !q_empty && inst_ready && !flush;

  assign inst_valid          = !q_empty;
  assign {inst_pc, inst_data} = q_rdata;

  // Request/response sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_q <= S_REQ;
        S_REQ:   if (grant) state_q <= S_WAIT;
        S_WAIT:  if (imem_rvalid) state_q <= S_REQ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // PC capture at grant and drop tracking for responses orphaned by a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_cap_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (grant) pc_cap_q <= pc_value;
      if (flush && (((state_q == S_WAIT) && !imem_rvalid) || grant)) drop_q <= 1'b1;
      else if (resp)                                                  drop_q <= 1'b0;
    end
  end

  fetch_queue #(
    .WIDTH (N + INSTR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({pc_cap_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (q_rdata),
    .empty_o (q_empty),
    .count_o (q_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle stimulus table with expected
// imem_req / inst_valid, plus a scoreboard of {pc, instr} pushed when a
// response should be queued and popped when decode accepts the head.
module tb_instr_fetch_unit;
  import mips_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_value;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_hold;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  instr_fetch_unit #(.N(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_value    (pc_value),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_hold     (pc_hold),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] tgt;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        er;
    logic        ev;
  } vec_t;

  vec_t         vecs[$];
  fetch_entry_t sb[$];
  logic [31:0]  tb_pc;
  logic [31:0]  tb_cap;
  bit           tb_wait;
  bit           tb_drop;
  int           n_chk;
  int           n_fail;

  function automatic vec_t mk(logic fl, logic [31:0] tgt, logic g, logic rv,
                              logic [31:0] rd, logic rdy, logic er, logic ev);
    vec_t v;
    v.fl = fl; v.tgt = tgt; v.g = g; v.rv = rv;
    v.rd = rd; v.rdy = rdy; v.er = er; v.ev = ev;
    return v;
  endfunction

  function automatic void add(logic fl, logic [31:0] tgt, logic g, logic rv,
                              logic [31:0] rd, logic rdy, logic er, logic ev);
    vecs.push_back(mk(fl, tgt, g, rv, rd, rdy, er, ev));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at negedge
  task automatic cyc(input vec_t v);
    bit grant;
    bit resp;
    fetch_entry_t e;
    flush       = v.fl;
    imem_gnt    = v.g;
    imem_rvalid = v.rv;
    imem_rdata  = v.rd;
    inst_ready  = v.rdy;
    @(negedge clk);
    grant = imem_req && v.g;
    chk("imem_req", {63'd0, imem_req}, {63'd0, v.er});
    chk("pc_hold", {63'd0, pc_hold}, {63'd0, !grant});
    chk("imem_addr", {32'd0, imem_addr}, {32'd0, tb_pc});
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, v.ev});
    chk("inst_valid_vs_sb", {63'd0, inst_valid}, {63'd0, (sb.size() != 0)});
    if (inst_valid && v.rdy && !v.fl) begin
      if (sb.size() == 0) begin
        chk("pop_with_empty_scoreboard", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
        chk("inst_data", {32'd0, inst_data}, {32'd0, e.instr});
      end
    end
    resp = tb_wait && v.rv;
    if (resp && !tb_drop && !v.fl) begin
      e.pc = tb_cap;
      e.instr = v.rd;
      sb.push_back(e);
    end
    if (v.fl) sb.delete();
    if (v.fl && ((tb_wait && !v.rv) || grant)) tb_drop = 1'b1;
    else if (resp)                             tb_drop = 1'b0;
    if (grant)     tb_wait = 1'b1;
    else if (resp) tb_wait = 1'b0;
    if (grant) tb_cap = tb_pc;
    if (v.fl)       tb_pc = v.tgt;
    else if (grant) tb_pc = tb_pc + 32'd4;
    @(posedge clk);
    #1;
    pc_value = tb_pc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_pc_hold"}, {63'd0, pc_hold}, 64'd1);
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    chk({tag, "_inst_data"}, {32'd0, inst_data}, 64'd0);
    chk({tag, "_inst_pc"}, {32'd0, inst_pc}, 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    tb_wait = 1'b0;
    tb_drop = 1'b0;
    tb_cap = '0;
    tb_pc = 32'h0040_0000;
    rst = 1'b0;
    flush = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    inst_ready = 1'b0;
    pc_value = tb_pc;

    //   fl tgt          g  rv rd            rdy er ev
    // reset release, gnt held, rvalid one cycle after grant
    add(0, 32'h0,        1, 0, 32'h0,        1, 0, 0);
    add(0, 32'h0,        1, 0, 32'h0,        1, 1, 0);
    add(0, 32'h0,        1, 1, 32'h2008_0005, 1, 0, 0);
    add(0, 32'h0,        0, 0, 32'h0,        1, 1, 1);
    // backpressure: two fetches fill DEPTH=2, request stops until a pop
    add(1, 32'h0,        0, 0, 32'h0,        0, 1, 0);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 0);
    add(0, 32'h0,        0, 1, 32'hA000_0001, 0, 0, 0);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 1);
    add(0, 32'h0,        0, 1, 32'hA000_0002, 0, 0, 1);
    add(0, 32'h0,        1, 0, 32'h0,        0, 0, 1);
    add(0, 32'h0,        1, 0, 32'h0,        0, 0, 1);
    add(0, 32'h0,        1, 0, 32'h0,        1, 0, 1);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 1);
    add(0, 32'h0,        0, 1, 32'hA000_0003, 0, 0, 1);
    add(0, 32'h0,        0, 0, 32'h0,        1, 0, 1);
    add(0, 32'h0,        0, 0, 32'h0,        1, 1, 1);
    // grant withheld five cycles at 0x10
    add(1, 32'h10,       0, 0, 32'h0,        0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 32'h0, 0, 0, 32'h0, 0, 1, 0);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 0);
    add(0, 32'h0,        0, 1, 32'h1111_0010, 0, 0, 0);
    add(0, 32'h0,        0, 0, 32'h0,        1, 1, 1);
    // flush in S_WAIT with one entry queued; late rvalid is dropped
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 0);
    add(0, 32'h0,        0, 1, 32'hC000_0001, 0, 0, 0);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 1);
    add(1, 32'h100,      0, 0, 32'h0,        0, 0, 1);
    add(0, 32'h0,        0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 0);
    add(0, 32'h0,        0, 1, 32'hD000_0100, 0, 0, 0);
    add(0, 32'h0,        0, 0, 32'h0,        1, 1, 1);
    // flush together with rvalid and a pop
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 0);
    add(0, 32'h0,        0, 1, 32'hE000_0001, 0, 0, 0);
    add(0, 32'h0,        1, 0, 32'h0,        0, 1, 1);
    add(1, 32'h200,      0, 1, 32'hE000_0002, 1, 0, 1);
    add(0, 32'h0,        0, 0, 32'h0,        1, 1, 0);
    add(0, 32'h0,        1, 0, 32'h0,        1, 1, 0);
    add(0, 32'h0,        0, 1, 32'hE000_0200, 1, 0, 0);
    add(0, 32'h0,        0, 0, 32'h0,        1, 1, 1);

    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vecs[i]) cyc(vecs[i]);

    // reset asserted mid-S_WAIT, late rvalid arrives during and after reset
    cyc(mk(0, 32'h0, 1, 0, 32'h0, 0, 1, 0));
    imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    tb_wait = 1'b0;
    tb_drop = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(mk(0, 32'h0, 0, 1, 32'hBAD0_0001, 1, 0, 0));
    cyc(mk(0, 32'h0, 0, 1, 32'hBAD0_0002, 1, 1, 0));
    cyc(mk(0, 32'h0, 0, 0, 32'h0,         1, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
